// File: rtl/mp_add_pkg.sv
// Shared types and defaults for the multi-precision add sequencer.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DEF = 32;
  localparam int N_DEF = 8;

  // Chunk counter width; a single-chunk build still needs a 1-bit counter.
  function automatic int cnt_width(input int chunks);
    return (chunks <= 1) ? 1 : $clog2(chunks);
  endfunction

endpackage

// File: rtl/mp_add_seq_adder.sv
// N-bit ripple adder with carry in/out, used for one chunk per cycle.
module adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mp_add_seq.sv
// Multi-cycle W-bit adder built from one N-bit adder, valid/ready in and out.
// Optional subtract mode is enabled with `define MP_ADD_SUB_EN.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef MP_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         result_valid,
  input  logic         result_ready,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);

  localparam int CHUNKS = W / N;
  localparam int CW = cnt_width(CHUNKS);
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  state_t state, state_next;

  logic [W-1:0]  a_r, b_r, s_r;
  logic          carry_r, ovf_r;
  logic [CW-1:0] cnt;

  logic [W-1:0]  b_in;
  logic          cin_in;
  logic [N-1:0]  chunk_sum;
  logic          chunk_cout;
  logic          last_chunk;

`ifdef MP_ADD_SUB_EN
  // Two's-complement subtract: a + ~b + 1, so the caller's cin is overridden.
  assign b_in   = sub ? ~b : b;
  assign cin_in = sub ? 1'b1 : cin;
`else
  assign b_in   = b;
  assign cin_in = cin;
`endif

  adder #(.N(N)) u_adder (
    .a    (a_r[N-1:0]),
    .b    (b_r[N-1:0]),
    .cin  (carry_r),
    .s    (chunk_sum),
    .cout (chunk_cout)
  );

  assign last_chunk = (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves a signal unassigned and infers a latch.
  always_comb begin
    state_next   = state;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_next = RUN;
      end
      RUN: begin
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: operand shift registers are not reset; they are always loaded on
  // accept before use, so only the architecturally visible state is cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_r     <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_r     <= a;
            b_r     <= b_in;
            carry_r <= cin_in;
            cnt     <= '0;
          end
        end
        RUN: begin
          // Chunks arrive LSB first and are shifted in from the top.
          s_r     <= (s_r >> N) | (W'(chunk_sum) << (W - N));
          a_r     <= a_r >> N;
          b_r     <= b_r >> N;
          carry_r <= chunk_cout;
          if (last_chunk) begin
            ovf_r <= (a_r[N-1] == b_r[N-1]) && (chunk_sum[N-1] != a_r[N-1]);
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s    = s_r;
  assign cout = carry_r;
  assign ovf  = ovf_r;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed self-checking bench for mp_add_seq at W=32, N=8.
module tb_mp_add_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] a, b;
  logic        cin;
  logic        sub_i;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] s;
  logic        cout, ovf, busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mp_add_seq #(.W(32), .N(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .cin          (cin),
`ifdef MP_ADD_SUB_EN
    .sub          (sub_i),
`endif
    .result_valid (result_valid),
    .result_ready (result_ready),
    .s            (s),
    .cout         (cout),
    .ovf          (ovf),
    .busy         (busy)
  );

  // Launch one operation, wait for result_valid, capture outputs, then accept.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tcin, input logic tsub,
                        output logic [31:0] rs, output logic rc,
                        output logic ro, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; sub_i = tsub; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = 'x; b = 'x; cin = 1'bx;
    lat = 1;
    while (!result_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = s; rc = cout; ro = ovf;
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [31:0] ta,
                          input logic [31:0] tb_v, input logic tcin,
                          input logic tsub, input logic [31:0] es,
                          input logic ec, input logic eo);
    logic [31:0] rs;
    logic rc, ro;
    int lat;
    run_op(ta, tb_v, tcin, tsub, rs, rc, ro, lat);
    n_total++;
    if (lat >= 20) $display("FAIL %s timeout: no result_valid within %0d cycles", name, lat);
    else n_pass++;
    n_total++;
    if (rs !== es) $display("FAIL %s s: got %h expected %h", name, rs, es);
    else n_pass++;
    n_total++;
    if (rc !== ec) $display("FAIL %s cout: got %b expected %b", name, rc, ec);
    else n_pass++;
    n_total++;
    if (ro !== eo) $display("FAIL %s ovf: got %b expected %b", name, ro, eo);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1; start_valid = 1'b1; result_ready = 1'b0;
    a = 32'h1234; b = 32'h1; cin = 1'b0; sub_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({start_ready, result_valid, busy, cout, ovf} !== 5'b10000 || s !== 32'h0)
      $display("FAIL reset_state: rdy=%b vld=%b busy=%b cout=%b ovf=%b s=%h expected 1 0 0 0 0 00000000",
               start_ready, result_valid, busy, cout, ovf, s);
    else n_pass++;
    n_total++;
    if (dut.cnt !== '0) $display("FAIL reset_cnt: got %0d expected 0", dut.cnt);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0; start_valid = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_wins_start: busy=%b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_latency;
    logic [31:0] rs;
    logic rc, ro;
    int lat;
    run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, rs, rc, ro, lat);
    n_total++;
    if (lat !== 5) $display("FAIL latency: got %0d cycles expected 5", lat);
    else n_pass++;
    n_total++;
    if (rs !== 32'h00000100 || rc !== 1'b0 || ro !== 1'b0)
      $display("FAIL carry_prop: got s=%h cout=%b ovf=%b expected 00000100 0 0", rs, rc, ro);
    else n_pass++;
  endtask

  task automatic test_arith;
    check_op("full_ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    check_op("signed_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    check_op("all_ones_cin", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    check_op("neg_ovf",     32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
    check_op("mixed",       32'h12345678, 32'h0F0F0F0F, 1'b1, 1'b0, 32'h21436588, 1'b0, 1'b0);
  endtask

`ifdef MP_ADD_SUB_EN
  task automatic test_sub;
    check_op("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    check_op("sub_7_5", 32'd7, 32'd5, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_backpressure;
    int lat;
    @(negedge clk);
    a = 32'h00000010; b = 32'h00000020; cin = 1'b0; sub_i = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_total++;
    if (!result_valid) $display("FAIL bp_timeout: result_valid never rose");
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_valid = (i == 1);
      a = 32'hDEAD0000; b = 32'h0000BEEF;
      @(posedge clk); #1;
      start_valid = 1'b0;
      n_total++;
      if (result_valid !== 1'b1 || start_ready !== 1'b0 || s !== 32'h00000030 ||
          cout !== 1'b0 || ovf !== 1'b0)
        $display("FAIL bp_hold_%0d: vld=%b rdy=%b s=%h cout=%b ovf=%b expected 1 0 00000030 0 0",
                 i, result_valid, start_ready, s, cout, ovf);
      else n_pass++;
    end
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    n_total++;
    if (result_valid !== 1'b0 || start_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL bp_release: vld=%b rdy=%b busy=%b expected 0 1 0", result_valid, start_ready, busy);
    else n_pass++;
    check_op("bp_next_op", 32'h00000100, 32'h00000023, 1'b1, 1'b0, 32'h00000124, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'h00000001; cin = 1'b0; sub_i = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (start_ready !== 1'b1 || result_valid !== 1'b0 || s !== 32'h0 || busy !== 1'b0 || cout !== 1'b0)
      $display("FAIL mid_run_reset: rdy=%b vld=%b s=%h busy=%b cout=%b expected 1 0 00000000 0 0",
               start_ready, result_valid, s, busy, cout);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      n_total++;
      if (result_valid !== 1'b0) $display("FAIL mid_run_discard: result_valid=%b expected 0", result_valid);
      else n_pass++;
    end
    check_op("after_reset", 32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    int first, second, acc;
    logic [31:0] last_s;
    first = -1; second = -1; acc = 0;
    @(negedge clk);
    a = 32'd3; b = 32'd4; cin = 1'b0; sub_i = 1'b0;
    start_valid = 1'b1; result_ready = 1'b1;
    for (int i = 0; i < 40 && acc < 2; i++) begin
      @(negedge clk);
      if (start_ready) begin
        if (acc == 0) first = cyc; else second = cyc;
        acc++;
      end
    end
    start_valid = 1'b0;
    last_s = 'x;
    for (int i = 0; i < 20 && !result_valid; i++) @(negedge clk);
    last_s = s;
    @(negedge clk);
    result_ready = 1'b0;
    n_total++;
    if (second - first !== 6)
      $display("FAIL b2b_spacing: got %0d cycles expected 6", second - first);
    else n_pass++;
    n_total++;
    if (last_s !== 32'd7) $display("FAIL b2b_result: got %h expected 00000007", last_s);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_arith();
`ifdef MP_ADD_SUB_EN
    test_sub();
`endif
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
